// File: rtl/memristor_booth_pkg.sv
`default_nettype none
// ============================================================================
// Module  : memristor_booth_pkg
// Purpose : Shared definitions for the memristor bit-serial Booth multiplier:
//           FSM state encoding, Booth operation encoding, the default operand
//           width and the {top,bottom} -> Booth operation decoder.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package memristor_booth_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the pair (q[i], q[i-1]):
  // 01 -> +M, 10 -> -M, 00/11 -> 0.
  function automatic booth_op_t booth_decode(input logic top, input logic bottom);
    case ({top, bottom})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/memristor_booth_pp_unit.sv
`default_nettype none
// ============================================================================
// Module  : memristor_booth_pp_unit
// Purpose : Combinational Booth partial-product generator. Sign-extends the
//           multiplicand to 2N bits, weights it by 2^step and applies the
//           Booth operation decoded from the current pair.
// Ports   : top     - Booth pair current bit q[i]
//           bottom  - Booth pair previous bit q[i-1]
//           delta_m - signed N-bit multiplicand
//           step    - index i of the pair being consumed
//           pp      - signed 2N-bit partial product
// Revision: 1.0 - initial release
// ============================================================================
module memristor_booth_pp_unit
  import memristor_booth_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int STEP_W = $clog2(N + 1)
) (
  input  logic                  top,
  input  logic                  bottom,
  input  logic signed [N-1:0]   delta_m,
  input  logic [STEP_W-1:0]     step,
  output logic signed [2*N-1:0] pp
);

  booth_op_t             op;
  logic signed [2*N-1:0] m_ext;
  logic signed [2*N-1:0] m_shift;

  always_comb begin
    op      = booth_decode(top, bottom);
    m_ext   = {{N{delta_m[N-1]}}, delta_m};
    m_shift = m_ext << step;
    case (op)
      BOOTH_ADD: pp = m_shift;
      BOOTH_SUB: pp = -m_shift;   // modulo 2^(2N); -(-2^(2N-1)) wraps harmlessly
      default:   pp = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memristor_infra_booth_4bit.sv
`default_nettype none
// ============================================================================
// Module  : memristor_infra_booth_4bit
// Purpose : Bit-serial radix-2 Booth multiplier. The multiplicand is applied
//           in parallel; the multiplier arrives LSB-first as one Booth pair
//           per clock. The edge that starts a run also consumes pair 0, so
//           the product is final after N consuming edges and is held in DONE
//           until start is released.
// Ports   : clk     - rising-edge clock
//           rst     - asynchronous active-low reset
//           start   - level run request (must fall and rise again to rerun)
//           top     - Booth pair current bit q[i]
//           bottom  - Booth pair previous bit q[i-1]
//           delta_m - signed N-bit multiplicand, stable during a run
//           result  - signed 2N-bit registered accumulator
//           done    - registered, high while in DONE
//                     (present only with MEMRISTOR_BOOTH_DONE_EN defined)
// Macro   : MEMRISTOR_BOOTH_DONE_EN - adds the done output port.
// Revision: 1.0 - initial release
// ============================================================================
module memristor_infra_booth_4bit
  import memristor_booth_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  top,
  input  logic                  bottom,
  input  logic signed [N-1:0]   delta_m,
  output logic signed [2*N-1:0] result
`ifdef MEMRISTOR_BOOTH_DONE_EN
  ,
  output logic                  done
`endif
);

  localparam int                STEP_W    = $clog2(N + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

  state_t                state;
  state_t                state_next;
  logic [STEP_W-1:0]     step;
  logic [STEP_W-1:0]     step_next;
  logic signed [2*N-1:0] acc;
  logic signed [2*N-1:0] acc_next;
  logic signed [2*N-1:0] pp;

  memristor_booth_pp_unit #(
    .N      (N),
    .STEP_W (STEP_W)
  ) u_pp (
    .top     (top),
    .bottom  (bottom),
    .delta_m (delta_m),
    .step    (step),
    .pp      (pp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      step  <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
      acc   <= acc_next;
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    acc_next   = acc;
    case (state)
      IDLE: begin
        // step is always 0 here, so pp is pair 0; the accumulator restarts
        // from zero on the same edge rather than in a separate load cycle.
        if (start) begin
          acc_next = pp;
          if (step == LAST_STEP) begin
            step_next  = '0;
            state_next = DONE;
          end else begin
            step_next  = step + STEP_W'(1);
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (!start) begin
          // Abort: keep the partial sum, rewind the pair index.
          step_next  = '0;
          state_next = IDLE;
        end else begin
          acc_next = acc + pp;
          if (step == LAST_STEP) begin
            step_next  = '0;
            state_next = DONE;
          end else begin
            step_next = step + STEP_W'(1);
          end
        end
      end
      DONE: begin
        if (!start) begin
          state_next = IDLE;
        end
      end
      default: begin
        step_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign result = acc;

`ifdef MEMRISTOR_BOOTH_DONE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= (state_next == DONE);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_memristor_infra_booth_4bit.sv
`default_nettype none
// ============================================================================
// Module  : tb_memristor_infra_booth_4bit
// Purpose : Directed self-checking bench for memristor_infra_booth_4bit with
//           hand-computed expected products.
// Revision: 1.0 - initial release
// ============================================================================
module tb_memristor_infra_booth_4bit;

  localparam int N = 4;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic                  top;
  logic                  bottom;
  logic signed [N-1:0]   delta_m;
  logic signed [2*N-1:0] result;
`ifdef MEMRISTOR_BOOTH_DONE_EN
  logic                  done;
`endif

  int total;
  int bad;

  memristor_infra_booth_4bit #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .top     (top),
    .bottom  (bottom),
    .delta_m (delta_m),
    .result  (result)
`ifdef MEMRISTOR_BOOTH_DONE_EN
    ,
    .done    (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one Booth pair and let one rising edge consume it; returns #1 after it.
  task automatic step_pair(input logic t, input logic b);
    top    = t;
    bottom = b;
    @(posedge clk);
    #1;
  endtask

  // Run a full product: pairs given as {t0,b0,t1,b1,t2,b2,t3,b3}. start stays high.
  task automatic run_pairs(input logic [3:0] dm, input logic [7:0] pairs);
    delta_m = dm;
    start   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_pair(pairs[7-2*i], pairs[6-2*i]);
    end
  endtask

  task automatic release_start();
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    start   = 1'b0;
    top     = 1'b0;
    bottom  = 1'b0;
    delta_m = '0;
    #12;
    check("reset_result", result, 8'h00);
`ifdef MEMRISTOR_BOOTH_DONE_EN
    check("reset_done", {7'd0, done}, 8'h00);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_hold", result, 8'h00);

    // 7*3: pairs (1,0),(1,1),(0,1),(0,0)
    delta_m = 4'b0111;
    start   = 1'b1;
    step_pair(1'b1, 1'b0);
    step_pair(1'b1, 1'b1);
    step_pair(1'b0, 1'b1);
`ifdef MEMRISTOR_BOOTH_DONE_EN
    check("done_low_in_run", {7'd0, done}, 8'h00);
`endif
    step_pair(1'b0, 1'b0);
    check("7x3", result, 8'd21);
`ifdef MEMRISTOR_BOOTH_DONE_EN
    check("done_high", {7'd0, done}, 8'h01);
`endif
    // start held high in DONE with fresh pairs: no restart
    step_pair(1'b1, 1'b0);
    step_pair(1'b0, 1'b1);
    check("7x3_held", result, 8'd21);
    release_start();
    check("idle_after_done", result, 8'd21);
`ifdef MEMRISTOR_BOOTH_DONE_EN
    check("done_cleared", {7'd0, done}, 8'h00);
`endif

    run_pairs(4'b1001, 8'b10_01_10_11);
    check("m7xm3", result, 8'd21);
    release_start();

    run_pairs(4'b1001, 8'b10_11_01_00);
    check("m7x3", result, 8'hEB);
    release_start();

    run_pairs(4'b0111, 8'b10_01_10_11);
    check("7xm3", result, 8'hEB);
    release_start();

    run_pairs(4'b1000, 8'b00_00_00_10);
    check("m8xm8", result, 8'd64);
    release_start();

    run_pairs(4'b0111, 8'b00_00_00_10);
    check("7xm8", result, 8'hC8);
    release_start();

    run_pairs(4'b0000, 8'b10_01_10_01);
    check("0x5", result, 8'h00);
    release_start();

    // Reset mid-run after two pairs of 7*3 (partial sum -7)
    delta_m = 4'b0111;
    start   = 1'b1;
    step_pair(1'b1, 1'b0);
    step_pair(1'b1, 1'b1);
    check("partial_before_rst", result, 8'hF9);
    rst = 1'b0;
    #1;
    check("async_reset", result, 8'h00);
    start = 1'b0;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_pairs(4'b0111, 8'b10_11_01_00);
    check("7x3_after_rst", result, 8'd21);
    release_start();

    // Abort during RUN after two pairs: partial held, next run correct
    delta_m = 4'b0111;
    start   = 1'b1;
    step_pair(1'b1, 1'b0);
    step_pair(1'b1, 1'b1);
    release_start();
    check("abort_hold", result, 8'hF9);
    step_pair(1'b0, 1'b1);
    check("abort_idle", result, 8'hF9);
    run_pairs(4'b1001, 8'b10_11_01_00);
    check("m7x3_after_abort", result, 8'hEB);
`ifdef MEMRISTOR_BOOTH_DONE_EN
    check("done_after_abort_run", {7'd0, done}, 8'h01);
`endif
    release_start();

    // Restart: low then high gives a new product
    run_pairs(4'b1000, 8'b00_00_00_10);
    check("restart_m8xm8", result, 8'd64);
    release_start();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
